// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_t : receiver FSM state encoding
//   DATA_BITS  : payload bits per frame (8N1)
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-high reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output (two clocks of latency)
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver, 8N1, LSB first, idle-high line.
//   wb_clk_i  : sole clock
//   wb_rst_i  : asynchronous active-high reset
//   rx        : serial input line
//   rx_data   : last accepted byte
//   rx_valid  : rx_data holds an unread byte
//   rx_clear  : single-cycle acknowledge, clears rx_valid/frame_err/overrun
//   frame_err : sticky, a stop bit was sampled low
//   overrun   : sticky, a good byte arrived while rx_valid was still set
//   busy      : receiver is not in IDLE
//   irq       : rx_valid | frame_err | overrun
//   state_dbg : current FSM state, for observation only
//
// Handshake: rx_valid rises when a byte is accepted and stays high until
// rx_clear is seen on a clock edge. A byte completing in the same cycle as
// rx_clear is accepted (the clear makes room for it), so no overrun occurs.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167,
    parameter int CNT_W        = 13
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_clear,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 irq,
    output rx_state_t            state_dbg
);

    // Mid-point of the start bit, and the last count of a full bit period.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

    logic rxs;
    logic rxs_q;   // previous rxs, for falling-edge detection

    rx_state_t            state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [2:0]           bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 stop_ok, stop_bad;
    logic                 load_byte, lose_byte;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(wb_clk_i),
        .rst(wb_rst_i),
        .d  (rx),
        .q  (rxs)
    );

    // State and datapath registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rxs_q   <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            rxs_q   <= rxs;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        stop_ok      = 1'b0;
        stop_bad     = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                // Only a true 1->0 edge starts a frame, so a stuck-low line
                // does not retrigger after a glitch rejection.
                if (rxs_q && !rxs) begin
                    state_next = START;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift[DATA_BITS-1:1]};
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    stop_ok    = rxs;
                    stop_bad   = !rxs;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign load_byte = stop_ok && (!rx_valid || rx_clear);
    assign lose_byte = stop_ok && rx_valid && !rx_clear;

    // Host-visible flags. A new event takes priority over a same-cycle clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load_byte) begin
                rx_data <= shift;
            end

            if (load_byte) begin
                rx_valid <= 1'b1;
            end else if (rx_clear) begin
                rx_valid <= 1'b0;
            end

            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (rx_clear) begin
                frame_err <= 1'b0;
            end

            if (lose_byte) begin
                overrun <= 1'b1;
            end else if (rx_clear) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign irq       = rx_valid | frame_err | overrun;
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl with CLKS_PER_BIT = 16.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int CPB        = 16;
    localparam int FRAME_CYC  = 11 * CPB;   // start + 8 data + stop + idle gap
    // First posedge seeing the start bit is cycle 0; the stop-bit decision
    // edge is 2 (sync) + 8 (half bit) + 8*16 (data) + 16 (stop) = 154.
    localparam int STOP_EDGE  = 154;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy, irq;
    rx_state_t  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (5)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_clear (rx_clear),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy),
        .irq      (irq),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare rx_data against the oldest accepted byte the bench expects.
    task automatic check_byte(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(rx_data), 32'(e));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(rx_data),   32'h00);
        check({tag, "_valid"}, 32'(rx_valid),  32'd0);
        check({tag, "_ferr"},  32'(frame_err), 32'd0);
        check({tag, "_ovr"},   32'(overrun),   32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_irq"},   32'(irq),       32'd0);
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        rx_clear = 1'b1;
        @(negedge clk);
        rx_clear = 1'b0;
    endtask

    // Drive one frame. Iteration c sets the line at a negedge; the posedge
    // that follows is "cycle c". clear_at pulses rx_clear into that edge;
    // abort_at asserts reset mid-frame and abandons the rest of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int clear_at, input int abort_at);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                check("abort_busy_before_rst", 32'(busy), 32'd1);
                rst = 1'b1;
                #1;
                check_all_zero("in_reset");
                check("in_reset_state", 32'(state_dbg), 32'(IDLE));
                @(negedge clk);
                rx  = 1'b1;
                rst = 1'b0;
                rx_clear = 1'b0;
                return;
            end
            rx       = (c < 10 * CPB) ? bits[c / CPB] : 1'b1;
            rx_clear = (c == clear_at);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;

        // Reset state
        #1;
        check_all_zero("reset");
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Good frame 0x3D, then acknowledge
        exp_q.push_back(8'h3D);
        send_frame(8'h3D, 1'b1, -1, -1);
        check_byte("f3d_data");
        check("f3d_valid", 32'(rx_valid), 32'd1);
        check("f3d_irq",   32'(irq),      32'd1);
        check("f3d_busy",  32'(busy),     32'd0);
        check("f3d_ferr",  32'(frame_err), 32'd0);
        pulse_clear();
        check("clr_valid", 32'(rx_valid), 32'd0);
        check("clr_irq",   32'(irq),      32'd0);
        check("clr_data",  32'(rx_data),  32'h3D);

        // Start-bit glitch: 4 cycles low
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        waited = 0;
        while (busy && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_valid",   32'(rx_valid),  32'd0);
        check("glitch_ferr",    32'(frame_err), 32'd0);
        check("glitch_ovr",     32'(overrun),   32'd0);
        repeat (20) @(negedge clk);
        check("glitch_no_retrigger", 32'(busy), 32'd0);

        // Framing error on 0x0F from a clean reset
        pulse_reset();
        send_frame(8'h0F, 1'b0, -1, -1);
        check("ferr_flag",  32'(frame_err), 32'd1);
        check("ferr_irq",   32'(irq),       32'd1);
        check("ferr_valid", 32'(rx_valid),  32'd0);
        check("ferr_data",  32'(rx_data),   32'h00);
        check("ferr_ovr",   32'(overrun),   32'd0);
        pulse_clear();
        check("ferr_clr",     32'(frame_err), 32'd0);
        check("ferr_clr_irq", 32'(irq),       32'd0);

        // Overrun: 0x0F then 0x3D, no acknowledge
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, -1, -1);
        check("ovr_first_valid", 32'(rx_valid), 32'd1);
        check("ovr_first_ovr",   32'(overrun),  32'd0);
        send_frame(8'h3D, 1'b1, -1, -1);
        check_byte("ovr_data");
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_flag",  32'(overrun),  32'd1);
        check("ovr_irq",   32'(irq),      32'd1);
        pulse_clear();
        check("ovr_clr_flag",  32'(overrun),  32'd0);
        check("ovr_clr_valid", 32'(rx_valid), 32'd0);

        // Acknowledge in the same cycle as the stop-bit sample
        send_frame(8'h0F, 1'b1, -1, -1);
        check("race_first_data", 32'(rx_data), 32'h0F);
        exp_q.push_back(8'h3D);
        send_frame(8'h3D, 1'b1, STOP_EDGE, -1);
        check_byte("race_data");
        check("race_valid", 32'(rx_valid), 32'd1);
        check("race_ovr",   32'(overrun),  32'd0);

        // Reset during data bit 3, then a clean 0xA5
        send_frame(8'hC3, 1'b1, -1, 4 * CPB + 6);
        repeat (40) @(negedge clk);
        check_all_zero("post_rst");
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1);
        check_byte("a5_data");
        check("a5_valid", 32'(rx_valid),  32'd1);
        check("a5_ferr",  32'(frame_err), 32'd0);
        check("a5_ovr",   32'(overrun),   32'd0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4167, clocks per bit (40 MHz / 9600 baud); legal range 8 or more.
REQ-002 SHALL have parameter CNT_W, default 13, bit-counter width; CNT_W SHALL satisfy 2^CNT_W > CLKS_PER_BIT.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  serial line, 8N1, idle high, LSB first.
REQ-006 SHALL have port rx_data  output  8  last accepted byte.
REQ-007 SHALL have port rx_valid  output  1  unread byte present in rx_data.
REQ-008 SHALL have port rx_clear  input  1  single-cycle acknowledge; clears rx_valid, frame_err and overrun.
REQ-009 SHALL have port frame_err  output  1  sticky flag: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky flag: byte lost while rx_valid was high.
REQ-011 SHALL have port busy  output  1  high while state is not IDLE.
REQ-012 SHALL have port irq  output  1  rx_valid OR frame_err OR overrun.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer whose flops reset to 1; all logic SHALL use the synchronized value rxs.
REQ-014 SHALL implement states IDLE, START, DATA and STOP.
- One bit-period counter of width CNT_W.
- One bit index of width 3.
REQ-015 IDLE SHALL move to START on a 1-to-0 transition of rxs, with the counter cleared; a line held low SHALL NOT retrigger.
REQ-016 START SHALL sample rxs when the counter equals CLKS_PER_BIT/2-1.
- Sample 0: go to DATA, clear the counter and the bit index.
- Sample 1: treat as a glitch and return to IDLE; no flag is set.
REQ-017 DATA SHALL sample rxs each time the counter reaches CLKS_PER_BIT-1, then wrap the counter to 0.
- Each sample SHALL be shifted in LSB first.
- After the 8th sample the state SHALL go to STOP.
REQ-018 STOP SHALL sample rxs when the counter reaches CLKS_PER_BIT-1, then return to IDLE.
REQ-019 Stop sample = 1 with rx_valid = 0, or with rx_clear asserted in the same cycle:
- rx_data SHALL load the shift register on the next edge.
- rx_valid SHALL be 1 on the next edge.
- overrun SHALL NOT be set.
REQ-020 Stop sample = 1 with rx_valid = 1 and rx_clear = 0:
- rx_data SHALL be retained.
- The new byte SHALL be discarded.
- overrun SHALL be set to 1.
REQ-021 Stop sample = 0: frame_err SHALL be set to 1, the byte SHALL be discarded, and rx_data and rx_valid SHALL be unchanged.
REQ-022 rx_clear SHALL clear rx_valid, frame_err and overrun on the next edge, except as stated in REQ-019; rx_clear SHALL NOT affect reception in progress.
REQ-023 rx_valid, frame_err and overrun SHALL each hold until rx_clear or reset.
REQ-024 irq SHALL be a combinational OR of registered flags, with no added latency.
REQ-025 busy SHALL be combinational from the state register.

Reset
REQ-026 On wb_rst_i = 1, immediately and regardless of the current state:
- state = IDLE, counter = 0, bit index = 0, shift register = 0.
- rx_data = 0x00, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0, irq = 0.
- Synchronizer flops = 1.
REQ-027 A frame that is partly received when reset is asserted SHALL be dropped with no flag; reception SHALL resume at the first falling edge after reset is released.

Structure
REQ-028 Package uart_rx_pkg SHALL hold the state enum type and constant DATA_BITS = 8.
REQ-029 The synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset value parameter); all other logic SHALL be in uart_rx_ctrl.

Verification (CLKS_PER_BIT = 16)
REQ-030 Frame 0x3D, good stop bit -> rx_data = 0x3D, rx_valid = 1, irq = 1, busy = 0; then a 1-cycle rx_clear -> rx_valid = 0, irq = 0, rx_data still 0x3D.
REQ-031 rx low for 4 cycles, then high -> busy returns to 0 within 10 cycles; rx_valid, frame_err and overrun all stay 0.
REQ-032 Frame 0x0F with stop bit 0 -> frame_err = 1, irq = 1, rx_valid = 0, rx_data = 0x00; rx_clear -> frame_err = 0.
REQ-033 Frames 0x0F then 0x3D with no rx_clear -> rx_data = 0x0F, rx_valid = 1, overrun = 1.
REQ-034 Frame 0x0F received, then rx_clear pulsed in the same cycle as the 0x3D stop-bit sample -> rx_data = 0x3D, rx_valid = 1, overrun = 0.
REQ-035 wb_rst_i pulsed during data bit 3, then frame 0xA5 -> all outputs 0 during reset; afterwards rx_data = 0xA5, rx_valid = 1, frame_err = 0.
